// File: rtl/conv2_ctrl.sv
// conv2_ctrl: stream sequencer for the 5x5 conv2 layer, owns line-buffer write pointer and window issue.
// Ports: clk, rst_n (sync, active-low), start (arm a layer pass in IDLE), valid_in (pixel strobe),
//        in_ready (pixel accepted when valid_in && in_ready), wr_addr (buffer write address of the
//        pixel presented this cycle), win_valid/rd_col/row_base (window strobe, left column, oldest
//        row slot), ch_idx (current input map), frame_done/layer_done (completion pulses), busy.
// Optional macro CONV2_CTRL_STALL_EN adds stall_in (downstream back-pressure freezing intake in RUN).
module conv2_ctrl #(
  parameter int WIDTH       = 12,
  parameter int HEIGHT      = 12,
  parameter int FILTER_SIZE = 5,
  parameter int CHANNELS    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       valid_in,
`ifdef CONV2_CTRL_STALL_EN
  input  logic       stall_in,
`endif
  output logic       in_ready,
  output logic [7:0] wr_addr,
  output logic       win_valid,
  output logic [4:0] rd_col,
  output logic [2:0] row_base,
  output logic [1:0] ch_idx,
  output logic       frame_done,
  output logic       layer_done,
  output logic       busy
);
  localparam logic [4:0] COL_LAST  = 5'(WIDTH - 1);
  localparam logic [4:0] ROW_LAST  = 5'(HEIGHT - 1);
  localparam logic [4:0] K1        = 5'(FILTER_SIZE - 1);
  localparam logic [7:0] ADDR_LAST = 8'(WIDTH * FILTER_SIZE - 1);
  localparam logic [2:0] RB_LAST   = 3'(FILTER_SIZE - 1);
  localparam logic [1:0] CH_LAST   = 2'(CHANNELS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] in_col_q, in_col_d, in_row_q, in_row_d, rd_col_q, rd_col_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [2:0] rb_q, rb_d, row_base_q, row_base_d;
  logic [1:0] ch_q, ch_d;
  logic win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic layer_done_q, layer_done_d, busy_q, busy_d;
  logic start_go, accept, col_last, frame_end, win_hit;
`ifdef CONV2_CTRL_STALL_EN
  assign in_ready = (state_q == RUN) && !stall_in;
`else
  assign in_ready = (state_q == RUN);
`endif
  assign start_go  = (state_q == IDLE) && start;
  assign accept    = valid_in && in_ready;
  assign col_last  = (in_col_q == COL_LAST);
  assign frame_end = col_last && (in_row_q == ROW_LAST);
  assign win_hit   = (in_row_q >= K1) && (in_col_q >= K1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      wr_addr_q    <= '0;
      rb_q         <= '0;
      ch_q         <= '0;
      win_valid_q  <= 1'b0;
      rd_col_q     <= '0;
      row_base_q   <= '0;
      frame_done_q <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      wr_addr_q    <= wr_addr_d;
      rb_q         <= rb_d;
      ch_q         <= ch_d;
      win_valid_q  <= win_valid_d;
      rd_col_q     <= rd_col_d;
      row_base_q   <= row_base_d;
      frame_done_q <= frame_done_d;
      layer_done_q <= layer_done_d;
      busy_q       <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (start_go) state_d = RUN;
    else if (state_q == RUN && accept && frame_end && ch_q == CH_LAST) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  // rb_q tracks (in_row - (FILTER_SIZE-1)) mod FILTER_SIZE; it steps when a row at or past
  // FILTER_SIZE-1 completes, so the oldest row slot rotates without a divider.
  always_comb begin
    in_col_d     = start_go || (accept && col_last) ? '0 : accept ? in_col_q + 5'd1 : in_col_q;
    in_row_d     = start_go || (accept && frame_end) ? '0 : (accept && col_last) ? in_row_q + 5'd1 : in_row_q;
    wr_addr_d    = start_go || (accept && (frame_end || wr_addr_q == ADDR_LAST)) ? '0 :
                   accept ? wr_addr_q + 8'd1 : wr_addr_q;
    rb_d         = start_go || (accept && frame_end) ? '0 :
                   (accept && col_last && in_row_q >= K1) ? (rb_q == RB_LAST ? '0 : rb_q + 3'd1) : rb_q;
    ch_d         = start_go ? '0 : (accept && frame_end && ch_q != CH_LAST) ? ch_q + 2'd1 : ch_q;
    win_valid_d  = accept && win_hit;
    rd_col_d     = (accept && win_hit) ? in_col_q - K1 : rd_col_q;
    row_base_d   = (accept && win_hit) ? rb_q : row_base_q;
    frame_done_d = accept && frame_end;
    layer_done_d = (state_q == DONE);
    // busy stays up through the layer_done cycle, which follows the DONE state by one edge
    busy_d       = (state_d != IDLE) || (state_q == DONE);
  end
  assign wr_addr    = wr_addr_q;
  assign win_valid  = win_valid_q;
  assign rd_col     = rd_col_q;
  assign row_base   = row_base_q;
  assign ch_idx     = ch_q;
  assign frame_done = frame_done_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;
endmodule

// File: doc/conv2_ctrl.md
# conv2_ctrl

Stream sequencer for the 2nd convolution layer (5×5 kernel).
- Accepts the pixel stream of each input feature map and owns the write pointer of the 5-row circular line buffer.
- Tracks input row and column. For every valid 5×5 window it emits the window's left column, the rotation slot of its oldest row, and a window-valid strobe.
- Loops over CHANNELS input maps and reports frame and layer completion.
- Sits between the conv1/maxpool output stream and the conv2 line buffer plus MAC array.

## Interface
- WIDTH, 12, input map width in pixels
- HEIGHT, 12, input map height in pixels
- FILTER_SIZE, 5, kernel edge; the line buffer holds this many rows
- CHANNELS, 3, input maps per layer pass
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that arms a layer pass; honoured only in IDLE
- valid_in  in  1  input pixel strobe; a pixel is accepted when valid_in && in_ready
- in_ready  out  1  controller can accept a pixel this cycle
- wr_addr  out  8  line-buffer write address for the pixel accepted this cycle
- win_valid  out  1  rd_col and row_base describe a complete window
- rd_col  out  5  left column of the window, 0..WIDTH-FILTER_SIZE
- row_base  out  3  buffer row slot holding the window's top row, 0..FILTER_SIZE-1
- ch_idx  out  2  current input channel, 0..CHANNELS-1
- frame_done  out  1  one-cycle pulse that accompanies the last window of a map
- layer_done  out  1  one-cycle pulse after all CHANNELS maps
- busy  out  1  state is not IDLE

## Operation
- States are IDLE, RUN and DONE.
  - IDLE: in_ready=0. On start, go to RUN and clear ch_idx, counters and wr_addr.
  - RUN: in_ready=1.
  - DONE: lasts exactly one cycle with layer_done=1 and in_ready=0, then returns to IDLE.
- Counters are in_col (0..WIDTH-1) and in_row (0..HEIGHT-1). They advance only on an accepted pixel.
  - in_col wraps to 0 at WIDTH-1 and increments in_row.
- wr_addr advances by 1 on each accepted pixel and wraps to 0 after WIDTH*FILTER_SIZE-1. This is 59 by default.
- Window condition, evaluated on the accepted pixel: in_row ≥ FILTER_SIZE-1 and in_col ≥ FILTER_SIZE-1.
  - rd_col = in_col − (FILTER_SIZE−1).
  - row_base = (in_row − (FILTER_SIZE−1)) mod FILTER_SIZE, kept as a wrapping 0..4 counter with no divider.
- End of frame: the accepted pixel is at (HEIGHT-1, WIDTH-1).
  - frame_done is asserted and in_row, in_col, wr_addr and row_base are cleared.
  - If ch_idx == CHANNELS-1, go to DONE. Otherwise ch_idx increments and the state stays RUN.
- Windows per map = (WIDTH−FILTER_SIZE+1)·(HEIGHT−FILTER_SIZE+1), which is 64 by default.
- valid_in outside RUN is ignored and no counter moves. A start pulse outside IDLE is ignored.
- Gaps in valid_in are legal. Outputs hold and win_valid is 0 during gaps.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- wr_addr is valid in the cycle the pixel is presented: the buffer writes buffer[wr_addr] on accept.
- win_valid, rd_col, row_base and frame_done appear 1 cycle after the accepting edge. The window's last pixel is therefore already written when the window is read.
- win_valid is high for exactly one cycle per window. Back-to-back accepted pixels give back-to-back windows.
- ch_idx updates on the cycle frame_done is high.
- After the final frame_done, layer_done follows in the next cycle, and busy drops in the cycle after that.
- A reset mid-frame returns the block to IDLE at the next edge and discards all progress. Nothing is pulsed.

## Configuration
- Macro: CONV2_CTRL_STALL_EN.
- Defined: adds input port stall_in (1 bit, downstream back-pressure). In RUN, in_ready = !stall_in, so pixels are not accepted and counters freeze while stall_in is high.
- Not defined: the stall_in port is absent and in_ready=1 throughout RUN.

## Test plan
- Reset, then 1 map of 144 contiguous pixels after start:
  - first win_valid one cycle after the 53rd pixel, with rd_col=0 and row_base=0;
  - 64 win_valid pulses in total;
  - frame_done with the 64th pulse.
- Row rotation: the first window of input row 5 gives row_base=1, row 8 gives row_base=4, and row 9 gives row_base=0.
- wr_addr wrap: the 60th accepted pixel has wr_addr=59 and the 61st has wr_addr=0.
- Full layer of 432 pixels: three frame_done pulses with ch_idx moving 0→1→2; layer_done one cycle after the third; busy=0 one cycle after layer_done. Pixels sent afterwards are ignored.
- valid_in toggling 1,0,1,0: window count and positions identical to the contiguous case; win_valid=0 in gap cycles. A start pulsed mid-frame has no effect.
- rst_n low at pixel 70: all outputs 0 and busy=0 next cycle. A new start re-runs from wr_addr=0.
- With CONV2_CTRL_STALL_EN: a 10-cycle stall_in mid-row gives in_ready=0 and frozen counters, then the same 64 windows as without the stall.
